tff_count_ctrl: RTL and testbench
=================================

Name: tff_count_ctrl

Overview:
- Control stage directly upstream of a bank of WIDTH T flip-flops. Each flip-flop has clk, t and ld inputs, with t taking priority over ld, and has no reset.
- Debounces the operator buttons, runs a small run/stop/clear FSM and divides clk into count ticks.
- Uses feedback of the bank's q outputs to drive a one-cycle toggle vector, so the bank counts modulo MODULUS, up or down.
- Produces the clear (ld) pulse the bank uses, with t held low so ld takes effect.

Parameters:
- WIDTH, 4, number of T flip-flops in the controlled bank.
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 4, clk cycles per count tick; must be >= 2 so q_fb is settled before the next tick.
- DEBOUNCE, 3, consecutive stable synchronized samples required to accept a button level.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_run  in  1  raw run/stop button; a debounced rising edge toggles run/stop.
- btn_clr  in  1  raw clear button; a debounced rising edge clears the bank.
- dir  in  1  count direction, 0 = up, 1 = down; synchronized only, not debounced; sampled at each tick.
- q_fb  in  WIDTH  feedback of the flip-flop bank's q outputs.
- t  out  WIDTH  registered toggle vector to the bank.
- ld  out  1  registered clear request to the bank.
- running  out  1  high while the FSM is in RUN.
- tc  out  1  one-cycle terminal-count pulse, issued with the wrapping t.

Behaviour:
- Reset (asynchronous): state=CLEAR, t=0, ld=1, running=0, tc=0; prescaler, debounce counters and synchronizers cleared. ld stays 1 for the whole reset, so the bank clears on every clk edge during reset.
- Input conditioning: btn_run, btn_clr and dir each pass through a 2-flop synchronizer.
  - Each button then has a debounce counter. The accepted level changes only after DEBOUNCE consecutive equal samples.
  - A rising edge of the accepted level gives a one-cycle press pulse.
  - Total latency from a clean press to the press pulse is 2 + DEBOUNCE cycles.
- FSM states: CLEAR, IDLE, RUN.
  - CLEAR: lasts one cycle with t=0 and ld=1, then goes to IDLE.
  - IDLE: t=0, ld=0. A run press goes to RUN. A clr press goes to CLEAR.
  - RUN: a run press goes to IDLE. A clr press goes to CLEAR.
  - A clr press in RUN or IDLE overrides a simultaneous run press; the FSM ends in IDLE after CLEAR.
- Prescaler: counts 0..PRESCALE-1 only while in RUN. It resets to 0 on entry to RUN and on leaving RUN. tick is asserted when the count equals PRESCALE-1.
- Toggle generation: on the clock edge where tick is true in RUN, t is registered for exactly one cycle; it is 0 at all other times.
  - Up, q_fb < MODULUS-1: t[0]=1, and t[i]=&q_fb[i-1:0] for i>0.
  - Up, q_fb == MODULUS-1: t=q_fb, so the bank wraps to 0, and tc=1.
  - Down, 0 < q_fb < MODULUS: t[0]=1, and t[i]=&~q_fb[i-1:0] for i>0.
  - Down, q_fb == 0: t=MODULUS-1, so the bank wraps to MODULUS-1, and tc=1.
  - q_fb >= MODULUS (unreset power-up garbage): up gives t=q_fb (next value 0); down gives t=q_fb^(MODULUS-1) (next value MODULUS-1). tc=1 in both cases.
- ld is 1 only in CLEAR and during reset, and is never asserted in the same cycle as nonzero t.
- running=1 exactly while state==RUN.
- tc is registered alongside t and is 0 otherwise.
- Reset mid-RUN: outputs take their reset values immediately, asynchronously. The bank is cleared on the following edges; after release there is one more CLEAR cycle, then IDLE.
- Latency: a registered t or ld changes the bank's q at the next clk edge; q_fb is valid one cycle later.

Decomposition:
- Shared package: FSM state enum (CLEAR, IDLE, RUN), direction constants UP=0 and DOWN=1, and a function next_toggle(q, dir, modulus) implementing the toggle rules above.
- One natural sub-module, btn_debounce: a 2-flop synchronizer plus DEBOUNCE counter plus rising-edge pulse. It is instantiated twice, for run and clr. dir uses only a plain synchronizer.

Test Plan:
- Reset with 8 cycles held -> ld=1 and t=0 throughout; one ld=1 cycle after release, then IDLE with ld=0. Bench model bank q=0.
- Run press, dir=0, default parameters -> t pulses every 4 cycles. Bank sequence is 0,1,…,9,0; at 9->0, t=4'b1001 and tc=1 for one cycle.
- dir=1 from q=0 -> first tick gives t=4'b1001 (q becomes 9) with tc=1; following ticks step 8, 7, 6.
- Run and clr press edges in the same cycle while in RUN -> CLEAR cycle (ld=1, t=0), then IDLE, running=0, q=0.
- Bench bank preloaded to q=4'b1101 (13), up -> t=4'b1101, q becomes 0, tc=1. Same preload with down -> t=4'b0100, q becomes 9.
- btn_run bouncing 1-0-1 with glitches shorter than DEBOUNCE -> no press is accepted. A clean press held for 5 or more cycles -> exactly one run/stop toggle.

Source files
------------

// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and toggle-vector rule for the T flip-flop count controller.
//   state_t      : controller FSM states
//   UP / DOWN    : values of the dir input
//   next_toggle(): toggle vector plus terminal-count flag for one count step
package tff_count_ctrl_pkg;

    // Widest bank the toggle function supports; callers zero-extend q into it.
    localparam int unsigned MAX_W = 16;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    typedef struct packed {
        logic             tc;
        logic [MAX_W-1:0] t;
    } toggle_t;

    // Toggle vector that moves the bank one step modulo `modulus`.
    // Out-of-range q (power-up garbage) is forced onto 0 (up) or modulus-1 (down).
    function automatic toggle_t next_toggle(input logic [MAX_W-1:0] q,
                                            input logic             dir,
                                            input int unsigned      modulus);
        toggle_t          r;
        logic [MAX_W-1:0] last;
        logic             chain;
        r     = '0;
        last  = MAX_W'(modulus - 1);
        chain = 1'b1;
        if (dir == UP) begin
            if (32'(q) >= modulus - 1) begin
                r.t  = q;
                r.tc = 1'b1;
            end else begin
                for (int unsigned i = 0; i < MAX_W; i++) begin
                    r.t[i] = chain;
                    chain  = chain & q[i];
                end
            end
        end else begin
            if ((q == '0) || (32'(q) >= modulus)) begin
                r.t  = q ^ last;
                r.tc = 1'b1;
            end else begin
                for (int unsigned i = 0; i < MAX_W; i++) begin
                    r.t[i] = chain;
                    chain  = chain & ~q[i];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Operator inputs, bank feedback and bank control outputs of the controller.
//   slave  : controller side (buttons, dir, q_fb in; t, ld, running, tc out)
//   master : environment side (opposite directions)
interface tff_count_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             btn_run;
    logic             btn_clr;
    logic             dir;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] t;
    logic             ld;
    logic             running;
    logic             tc;

    modport slave (
        input  btn_run, btn_clr, dir, q_fb,
        output t, ld, running, tc
    );

    modport master (
        output btn_run, btn_clr, dir, q_fb,
        input  t, ld, running, tc
    );
endinterface

// File: rtl/tff_count_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
//   clk, rst : clock, async active-high reset
//   raw      : asynchronous button level
//   press    : one-cycle pulse when the accepted level rises
module tff_count_ctrl_btn_debounce #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;

    // The accepted level flips on the DEBOUNCE-th consecutive differing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            press  <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press    <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/tff_count_ctrl.sv
// Run/stop/clear controller for a bank of WIDTH T flip-flops counting modulo MODULUS.
//   clk, rst : clock, async active-high reset
//   bus      : btn_run, btn_clr, dir, q_fb in; t, ld, running, tc out (all registered)
module tff_count_ctrl
    import tff_count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 10,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst,
    tff_count_ctrl_if.slave   bus
);
    localparam int unsigned PW = $clog2(PRESCALE);

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       dir_sync_q;
    logic [WIDTH-1:0] t_q, t_d;
    logic             tc_q, tc_d;
    logic             ld_q;
    logic             running_q;
    logic             run_press;
    logic             clr_press;
    logic             tick;
    toggle_t          tg;

    tff_count_ctrl_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_run),
        .press (run_press)
    );

    tff_count_ctrl_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_clr_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_clr),
        .press (clr_press)
    );

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            pre_q      <= '0;
            dir_sync_q <= '0;
            t_q        <= '0;
            tc_q       <= 1'b0;
            ld_q       <= 1'b1;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            dir_sync_q <= {dir_sync_q[0], bus.dir};
            t_q        <= t_d;
            tc_q       <= tc_d;
            ld_q       <= (state_d == CLEAR);
            running_q  <= (state_d == RUN);
        end
    end

    // Next state, prescaler and toggle vector; clr wins over a simultaneous run press.
    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        t_d     = '0;
        tc_d    = 1'b0;
        tg      = '0;
        tick    = (state_q == RUN) && (pre_q == PW'(PRESCALE - 1));

        unique case (state_q)
            CLEAR: state_d = IDLE;
            IDLE: begin
                if (clr_press)      state_d = CLEAR;
                else if (run_press) state_d = RUN;
            end
            RUN: begin
                if (clr_press)      state_d = CLEAR;
                else if (run_press) state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase

        // Prescaler restarts from 0 whenever RUN is entered or left.
        if ((state_q == RUN) && (state_d == RUN)) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        // A tick on the edge that leaves RUN is dropped, so ld never meets a nonzero t.
        if (tick && (state_d == RUN)) begin
            tg   = next_toggle(MAX_W'(bus.q_fb), dir_sync_q[1], MODULUS);
            t_d  = WIDTH'(tg.t);
            tc_d = tg.tc;
        end
    end

    assign bus.t       = t_q;
    assign bus.tc      = tc_q;
    assign bus.ld      = ld_q;
    assign bus.running = running_q;
endmodule

// File: tb/tb_tff_count_ctrl.sv
module tb_tff_count_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         total = 0;
    int         bad   = 0;

    // Behavioural T flip-flop bank: t has priority over ld, no reset of its own.
    logic [3:0] q = 4'b0110;
    logic       pre_en = 1'b0;
    logic [3:0] pre_val = 4'd0;

    logic [3:0] exp_up_t  [10] = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF, 4'h1, 4'h9};
    logic [3:0] exp_dn_q  [4]  = '{4'd0, 4'd9, 4'd8, 4'd7};
    logic [3:0] exp_dn_t  [4]  = '{4'h9, 4'h1, 4'hF, 4'h1};
    logic       exp_dn_tc [4]  = '{1'b1, 1'b0, 1'b0, 1'b0};

    tff_count_ctrl_if #(.WIDTH(4)) bus ();

    tff_count_ctrl #(
        .WIDTH    (4),
        .MODULUS  (10),
        .PRESCALE (4),
        .DEBOUNCE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.q_fb = q;

    always @(posedge clk) begin
        if (pre_en) q <= pre_val;
        else        q <= (q ^ bus.t) & ~({4{bus.ld}} & ~bus.t);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_t(input int lim, output int waited);
        waited = 0;
        while (bus.t == 4'd0 && waited < lim) begin
            @(negedge clk);
            waited++;
        end
        chk("t_pulse_seen", 32'(bus.t != 4'd0), 32'd1);
    endtask

    task automatic wait_running(input logic val, input int lim);
        int n = 0;
        while (bus.running !== val && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("running_reached", 32'(bus.running), 32'(val));
    endtask

    task automatic wait_ld(input int lim);
        int n = 0;
        while (bus.ld !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("ld_seen", 32'(bus.ld), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic preload(input logic [3:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
        chk("preload_q", 32'(q), 32'(v));
    endtask

    initial begin
        int  w;
        logic seen;
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        bus.dir     = 1'b0;

        // Reset held 8 cycles: bank cleared, outputs at reset values.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_ld", 32'(bus.ld), 32'd1);
            chk("rst_t", 32'(bus.t), 32'd0);
        end
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_tc", 32'(bus.tc), 32'd0);
        chk("rst_bank_q", 32'(q), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_clear_ld", 32'(bus.ld), 32'd1);
        @(negedge clk);
        chk("idle_ld", 32'(bus.ld), 32'd0);
        chk("idle_running", 32'(bus.running), 32'd0);
        chk("idle_q", 32'(q), 32'd0);
        idle_cycles(3);
        chk("idle_t", 32'(bus.t), 32'd0);

        // Count up 0..9 and wrap, one pulse every 4 cycles.
        bus.btn_run = 1'b1;
        wait_running(1'b1, 20);
        bus.btn_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_t(12, w);
            if (i > 0) chk("up_period", 32'(w), 32'd3);
            chk("up_q", 32'(q), 32'(i));
            chk("up_t", 32'(bus.t), 32'(exp_up_t[i]));
            chk("up_tc", 32'(bus.tc), (i == 9) ? 32'd1 : 32'd0);
            if (i == 9) bus.dir = 1'b1;
            @(negedge clk);
            chk("up_t_one_cycle", 32'(bus.t), 32'd0);
            chk("up_tc_one_cycle", 32'(bus.tc), 32'd0);
        end

        // Count down from 0: wrap to 9, then 8, 7, 6.
        for (int i = 0; i < 4; i++) begin
            wait_t(12, w);
            chk("dn_q", 32'(q), 32'(exp_dn_q[i]));
            chk("dn_t", 32'(bus.t), 32'(exp_dn_t[i]));
            chk("dn_tc", 32'(bus.tc), 32'(exp_dn_tc[i]));
            @(negedge clk);
        end
        chk("dn_final_q", 32'(q), 32'd6);

        // Run and clr pressed together while running: clear wins, then IDLE.
        bus.btn_run = 1'b1;
        bus.btn_clr = 1'b1;
        wait_ld(20);
        chk("clr_t_zero", 32'(bus.t), 32'd0);
        chk("clr_running", 32'(bus.running), 32'd0);
        @(negedge clk);
        chk("clr_then_ld", 32'(bus.ld), 32'd0);
        chk("clr_then_q", 32'(q), 32'd0);
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        idle_cycles(10);
        chk("clr_idle_running", 32'(bus.running), 32'd0);
        chk("clr_idle_q", 32'(q), 32'd0);

        // Garbage preload 13, up: wraps to 0.
        bus.dir = 1'b0;
        preload(4'd13);
        idle_cycles(3);
        bus.btn_run = 1'b1;
        wait_t(25, w);
        chk("garb_up_t", 32'(bus.t), 32'hD);
        chk("garb_up_tc", 32'(bus.tc), 32'd1);
        @(negedge clk);
        chk("garb_up_q", 32'(q), 32'd0);
        bus.btn_run = 1'b0;
        idle_cycles(6);
        bus.btn_run = 1'b1;
        wait_running(1'b0, 20);
        bus.btn_run = 1'b0;
        idle_cycles(10);

        // Garbage preload 13, down: wraps to 9.
        bus.dir = 1'b1;
        preload(4'd13);
        idle_cycles(3);
        bus.btn_run = 1'b1;
        wait_t(25, w);
        chk("garb_dn_t", 32'(bus.t), 32'h4);
        chk("garb_dn_tc", 32'(bus.tc), 32'd1);
        @(negedge clk);
        chk("garb_dn_q", 32'(q), 32'd9);
        bus.btn_run = 1'b0;
        idle_cycles(6);
        bus.btn_run = 1'b1;
        wait_running(1'b0, 20);
        bus.btn_run = 1'b0;
        idle_cycles(10);

        // Bouncing button with runs shorter than DEBOUNCE: never accepted.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_run = (i == 0 || i == 1 || i == 3 || i == 4 || i == 7);
            @(negedge clk);
            if (bus.running !== 1'b0) seen = 1'b1;
        end
        chk("bounce_no_press", 32'(seen), 32'd0);

        // Clean press held 6 cycles: exactly one toggle into RUN.
        bus.btn_run = 1'b1;
        idle_cycles(6);
        bus.btn_run = 1'b0;
        idle_cycles(15);
        chk("clean_press_running", 32'(bus.running), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
